// File: rtl/iob_ila_window_core_if.sv
// Signal bundle between the probed logic / ILA register bank and the window core.
// The register bank side is the master and the capture core is the slave.
interface iob_ila_window_core_if #(
  parameter int DATA_W    = 32,
  parameter int BUFFER_W  = 8,
  parameter int SIGNAL_W  = 8,
  parameter int TRIGGER_W = 2
);
  localparam int NSLICE = (SIGNAL_W + DATA_W - 1) / DATA_W;
  localparam int SEL_W  = (NSLICE <= 1) ? 1 : $clog2(NSLICE);

  logic                 rst_soft;
  logic                 arm;
  logic [SIGNAL_W-1:0]  signal;
  logic [TRIGGER_W-1:0] trigger;
  logic [TRIGGER_W-1:0] trigger_type;
  logic [TRIGGER_W-1:0] negate_trigger;
  logic [TRIGGER_W-1:0] trigger_mask;
  logic                 reduce_type;
  logic [BUFFER_W-1:0]  pre_samples;
  logic [BUFFER_W-1:0]  post_samples;
  logic [BUFFER_W-1:0]  index;
  logic [SEL_W-1:0]     value_select;
  logic [DATA_W-1:0]    value;
  logic [BUFFER_W:0]    samples;
  logic [BUFFER_W-1:0]  trigger_pos;
  logic [2:0]           state;
  logic                 busy;
  logic                 done;

  modport master (
    output rst_soft, arm, signal, trigger, trigger_type, negate_trigger,
           trigger_mask, reduce_type, pre_samples, post_samples, index, value_select,
    input  value, samples, trigger_pos, state, busy, done
  );

  modport slave (
    input  rst_soft, arm, signal, trigger, trigger_type, negate_trigger,
           trigger_mask, reduce_type, pre_samples, post_samples, index, value_select,
    output value, samples, trigger_pos, state, busy, done
  );
endinterface

// File: rtl/iob_ila_window_core.sv
// ILA capture engine: circular sample buffer with pre/post-trigger window and
// oldest-first sliced readback.
//   state | meaning
//   IDLE  | not capturing, buffer untouched
//   PRE   | filling the minimum pre-trigger history, trigger ignored
//   ARMED | sampling and evaluating the trigger
//   POST  | sampling the post-trigger tail
//   DONE  | window frozen for readback
module iob_ila_window_core #(
  parameter int DATA_W    = 32,
  parameter int BUFFER_W  = 8,
  parameter int SIGNAL_W  = 8,
  parameter int TRIGGER_W = 2
) (
  input logic                clk,
  input logic                rst,
  iob_ila_window_core_if.slave bus
);
  localparam int DEPTH  = 2 ** BUFFER_W;
  localparam int NSLICE = (SIGNAL_W + DATA_W - 1) / DATA_W;
  localparam int PAD_W  = NSLICE * DATA_W;
  localparam logic [BUFFER_W:0] DEPTH_V = (BUFFER_W + 1)'(DEPTH);
  localparam logic [BUFFER_W:0] ONE_S   = (BUFFER_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BUFFER_W-1:0]  wptr, post_cnt, trigger_pos_q;
  logic [BUFFER_W:0]    samples_q, samples_inc;
  logic [TRIGGER_W-1:0] latch, eff, contrib;
  logic                 fire, writing, clear;
  logic [SIGNAL_W-1:0]  mem [DEPTH];
  logic [BUFFER_W-1:0]  oldest, rd_addr;
  logic [PAD_W-1:0]     padded;
  logic [DATA_W-1:0]    rd_data, value_q;

  assign clear       = rst || bus.rst_soft;
  assign writing     = !clear && !bus.arm && (state_q inside {PRE, ARMED, POST});
  assign samples_inc = (samples_q == DEPTH_V) ? samples_q : samples_q + ONE_S;

  // Single-type bits count the cycle they are first seen as well as afterwards.
  assign eff     = bus.trigger ^ bus.negate_trigger;
  assign contrib = (bus.trigger_type & eff) | (~bus.trigger_type & (latch | eff));

  always_comb begin
    fire = 1'b0;
    if (bus.trigger_mask != '0) begin
      if (bus.reduce_type) fire = &(contrib | ~bus.trigger_mask);
      else                 fire = |(contrib & bus.trigger_mask);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRE:     if (samples_inc >= {1'b0, bus.pre_samples}) state_d = ARMED;
      ARMED:   if (fire) state_d = (bus.post_samples == '0) ? DONE : POST;
      POST:    if (post_cnt <= BUFFER_W'(1)) state_d = DONE;
      default: state_d = state_q;
    endcase
    if (bus.arm) state_d = (bus.pre_samples == '0) ? ARMED : PRE;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= IDLE;
      wptr          <= '0;
      samples_q     <= '0;
      latch         <= '0;
      post_cnt      <= '0;
      trigger_pos_q <= '0;
      value_q       <= '0;
    end else begin
      state_q <= state_d;
      value_q <= rd_data;
      if (bus.arm) begin
        wptr      <= '0;
        samples_q <= '0;
        latch     <= '0;
        post_cnt  <= '0;
      end else if (writing) begin
        wptr      <= wptr + BUFFER_W'(1);
        samples_q <= samples_inc;
        if (state_q == ARMED) begin
          latch <= latch | eff;
          if (fire) post_cnt <= bus.post_samples;
        end
        if (state_q == POST) post_cnt <= post_cnt - BUFFER_W'(1);
        if (state_d == DONE)
          trigger_pos_q <= BUFFER_W'(samples_inc - ONE_S - {1'b0, bus.post_samples});
      end
    end
  end

  // Buffer contents survive both resets.
  always_ff @(posedge clk) begin
    if (writing) mem[wptr] <= bus.signal;
  end

  assign oldest  = (samples_q == DEPTH_V) ? wptr : '0;
  assign rd_addr = oldest + bus.index;

  always_comb begin
    padded                 = '0;
    padded[SIGNAL_W-1:0]   = mem[rd_addr];
    rd_data                = '0;
    if (int'(bus.value_select) < NSLICE)
      rd_data = padded[int'(bus.value_select) * DATA_W +: DATA_W];
  end

  assign bus.value       = value_q;
  assign bus.samples     = samples_q;
  assign bus.trigger_pos = trigger_pos_q;
  assign bus.state       = state_q;
  assign bus.busy        = state_q inside {PRE, ARMED, POST};
  assign bus.done        = state_q == DONE;
endmodule

// File: tb/tb_iob_ila_window_core.sv
// Self-checking bench for iob_ila_window_core: capture scenarios from a table,
// readback through an expected-value queue, and hand-written restart/reset sequences.
module tb_iob_ila_window_core;
  localparam int DATA_W = 32, BUFFER_W = 4, SIGNAL_W = 40, TRIGGER_W = 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];

  iob_ila_window_core_if #(.DATA_W(DATA_W), .BUFFER_W(BUFFER_W),
                           .SIGNAL_W(SIGNAL_W), .TRIGGER_W(TRIGGER_W)) bus ();

  iob_ila_window_core #(.DATA_W(DATA_W), .BUFFER_W(BUFFER_W),
                        .SIGNAL_W(SIGNAL_W), .TRIGGER_W(TRIGGER_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       pre;
    int       post;
    bit       red;
    bit [1:0] ttype;
    bit [1:0] neg;
    bit [1:0] mask;
    int       t0a;
    int       t0b;
    int       t1from;
    int       exp_samples;
    int       exp_tpos;
  } scen_t;

  typedef struct {
    int          sc;
    int          idx;
    int          sel;
    logic [31:0] exp;
  } rd_t;

  scen_t scen[4];
  rd_t   rds[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int pre, input int post, input bit red, input bit [1:0] ttype,
                         input bit [1:0] neg, input bit [1:0] mask);
    bus.pre_samples    = 4'(pre);
    bus.post_samples   = 4'(post);
    bus.reduce_type    = red;
    bus.trigger_type   = ttype;
    bus.negate_trigger = neg;
    bus.trigger_mask   = mask;
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic run_capture(input int s);
    bit fin = 1'b0;
    @(negedge clk);
    set_cfg(scen[s].pre, scen[s].post, scen[s].red, scen[s].ttype, scen[s].neg, scen[s].mask);
    bus.trigger = '0;
    pulse_arm();
    chk($sformatf("s%0d_state_after_arm", s), bus.state, (scen[s].pre == 0) ? 2 : 1);
    for (int k = 1; k <= 60; k++) begin
      bus.signal     = {8'hA5, 32'(k)};
      bus.trigger[0] = (k == scen[s].t0a) || (k == scen[s].t0b);
      bus.trigger[1] = (scen[s].t1from != 0) && (k >= scen[s].t1from);
      @(posedge clk);
      #1;
      if (bus.done) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("s%0d_done", s), fin, 1);
    chk($sformatf("s%0d_state", s), bus.state, 4);
    chk($sformatf("s%0d_busy", s), bus.busy, 0);
    chk($sformatf("s%0d_samples", s), bus.samples, scen[s].exp_samples);
    chk($sformatf("s%0d_trigger_pos", s), bus.trigger_pos, scen[s].exp_tpos);
    for (int r = 0; r < 13; r++) begin
      if (rds[r].sc == s) begin
        @(negedge clk);
        bus.trigger      = '0;
        bus.index        = 4'(rds[r].idx);
        bus.value_select = 1'(rds[r].sel);
        exp_q.push_back(rds[r].exp);
        @(posedge clk);
        #1;
        chk($sformatf("s%0d_read_idx%0d_sel%0d", s, rds[r].idx, rds[r].sel),
            bus.value, exp_q.pop_front());
      end
    end
    @(negedge clk);
    bus.signal = '0;
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("s%0d_frozen_samples", s), bus.samples, scen[s].exp_samples);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    scen[0] = '{3, 2, 1'b0, 2'b00, 2'b00, 2'b11, 2, 6, 0, 8, 5};
    scen[1] = '{0, 0, 1'b1, 2'b10, 2'b00, 2'b11, 4, 0, 7, 7, 6};
    scen[2] = '{10, 10, 1'b0, 2'b00, 2'b00, 2'b11, 12, 0, 0, 16, 5};
    scen[3] = '{2, 1, 1'b0, 2'b00, 2'b01, 2'b11, 0, 0, 0, 4, 2};

    rds[0]  = '{0, 0, 0, 32'd1};
    rds[1]  = '{0, 5, 0, 32'd6};
    rds[2]  = '{0, 7, 0, 32'd8};
    rds[3]  = '{0, 5, 1, 32'h000000A5};
    rds[4]  = '{1, 6, 0, 32'd7};
    rds[5]  = '{1, 0, 0, 32'd1};
    rds[6]  = '{1, 3, 1, 32'h000000A5};
    rds[7]  = '{2, 0, 0, 32'd7};
    rds[8]  = '{2, 5, 0, 32'd12};
    rds[9]  = '{2, 15, 0, 32'd22};
    rds[10] = '{2, 15, 1, 32'h000000A5};
    rds[11] = '{3, 2, 0, 32'd3};
    rds[12] = '{3, 3, 0, 32'd4};

    rst = 1'b1;
    bus.rst_soft = 1'b0;
    bus.arm = 1'b0;
    bus.signal = '0;
    bus.trigger = '0;
    bus.index = '0;
    bus.value_select = '0;
    set_cfg(0, 0, 1'b0, 2'b00, 2'b00, 2'b11);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_value", bus.value, 0);
    chk("rst_samples", bus.samples, 0);
    chk("rst_trigger_pos", bus.trigger_pos, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;

    run_capture(0);

    // value follows index/value_select one edge later
    @(negedge clk);
    bus.index = 4'd7;
    bus.value_select = 1'b0;
    #1;
    chk("latency_hold", bus.value, 32'h000000A5);
    @(posedge clk);
    #1;
    chk("latency_new", bus.value, 32'd8);

    run_capture(1);
    run_capture(2);

    // all-zero mask never fires
    @(negedge clk);
    set_cfg(0, 0, 1'b0, 2'b00, 2'b00, 2'b00);
    bus.trigger = 2'b11;
    pulse_arm();
    repeat (40) @(posedge clk);
    #1;
    chk("mask0_state", bus.state, 2);
    chk("mask0_done", bus.done, 0);

    // arm while ARMED restarts the sample count
    @(negedge clk);
    set_cfg(0, 0, 1'b0, 2'b00, 2'b00, 2'b11);
    bus.trigger = 2'b00;
    pulse_arm();
    repeat (5) @(posedge clk);
    #1;
    chk("rearm_samples_before", bus.samples, 5);
    @(negedge clk);
    bus.arm = 1'b1;
    @(posedge clk);
    #1;
    chk("rearm_samples_cleared", bus.samples, 0);
    chk("rearm_state", bus.state, 2);
    @(negedge clk);
    bus.arm = 1'b0;
    @(posedge clk);
    #1;
    chk("rearm_samples_first", bus.samples, 1);

    // rst_soft while in POST
    @(negedge clk);
    set_cfg(1, 5, 1'b0, 2'b00, 2'b01, 2'b11);
    pulse_arm();
    repeat (2) @(posedge clk);
    #1;
    chk("soft_in_post", bus.state, 3);
    @(negedge clk);
    bus.rst_soft = 1'b1;
    @(posedge clk);
    #1;
    chk("soft_state", bus.state, 0);
    chk("soft_done", bus.done, 0);
    chk("soft_busy", bus.busy, 0);
    chk("soft_samples", bus.samples, 0);
    @(negedge clk);
    bus.rst_soft = 1'b0;

    run_capture(3);

    // reset beats a simultaneous arm
    @(negedge clk);
    rst = 1'b1;
    bus.arm = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_arm_state", bus.state, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.rst_soft = 1'b1;
    @(posedge clk);
    #1;
    chk("soft_arm_state", bus.state, 0);
    @(negedge clk);
    bus.rst_soft = 1'b0;
    bus.arm = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_reset_arm", bus.state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
